// File: rtl/oam_dma_engine.sv
// oam_dma_engine: sprite-attribute DMA engine.
// Copies LENGTH bytes from source page {page, idx} into OAM. It issues one
// source read, waits for the registered read data, then writes that byte into
// OAM. Byte issue is paced by the machine-cycle enable 'ce'. A start pulse
// restarts a transfer from any state, and all outputs are registered.

module oam_dma_engine #(
  parameter int LENGTH    = 160,
  parameter int OAM_AW    = 8,
  parameter int ECHO_FOLD = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              ce,
  input  logic              start,
  input  logic [7:0]        src_hi,
  output logic [15:0]       src_addr,
  output logic              src_rd,
  input  logic [7:0]        src_data,
  output logic [OAM_AW-1:0] oam_addr,
  output logic [7:0]        oam_data,
  output logic              oam_wren,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    ISSUE,
    WAIT,
    CAPTURE
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(LENGTH - 1);

  state_t            state, state_nxt;
  logic [7:0]        idx, idx_nxt;
  logic [7:0]        page, page_nxt;
  logic [15:0]       src_addr_nxt;
  logic              src_rd_nxt;
  logic [OAM_AW-1:0] oam_addr_nxt;
  logic [7:0]        oam_data_nxt;
  logic              oam_wren_nxt;
  logic              busy_nxt;
  logic              done_nxt;

  // Pages E0..FF mirror C0..DF (echo RAM) when folding is enabled.
  function automatic logic [7:0] fold(input logic [7:0] x);
    if ((ECHO_FOLD != 0) && (x >= 8'hE0))
      return x - 8'h20;
    else
      return x;
  endfunction

  // Next-state and next-output decode. A start pulse overrides every state,
  // including the completion step in CAPTURE, so the in-flight byte is dropped.
  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    page_nxt     = page;
    src_addr_nxt = src_addr;
    src_rd_nxt   = 1'b0;
    oam_addr_nxt = oam_addr;
    oam_data_nxt = oam_data;
    oam_wren_nxt = 1'b0;
    busy_nxt     = busy;
    done_nxt     = 1'b0;

    if (start) begin
      page_nxt  = fold(src_hi);
      idx_nxt   = 8'd0;
      busy_nxt  = 1'b1;
      state_nxt = ARM;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = IDLE;
        end
        ARM: begin
          if (ce)
            state_nxt = ISSUE;
        end
        ISSUE: begin
          if (ce) begin
            src_addr_nxt = {page, idx};
            src_rd_nxt   = 1'b1;
            state_nxt    = WAIT;
          end
        end
        WAIT: begin
          state_nxt = CAPTURE;
        end
        CAPTURE: begin
          oam_addr_nxt = OAM_AW'(idx);
          oam_data_nxt = src_data;
          oam_wren_nxt = 1'b1;
          if (idx == LAST_IDX) begin
            done_nxt  = 1'b1;
            busy_nxt  = 1'b0;
            state_nxt = IDLE;
          end else begin
            idx_nxt   = idx + 8'd1;
            state_nxt = ISSUE;
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state    <= IDLE;
      idx      <= 8'd0;
      page     <= 8'd0;
      src_addr <= 16'd0;
      src_rd   <= 1'b0;
      oam_addr <= '0;
      oam_data <= 8'd0;
      oam_wren <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      page     <= page_nxt;
      src_addr <= src_addr_nxt;
      src_rd   <= src_rd_nxt;
      oam_addr <= oam_addr_nxt;
      oam_data <= oam_data_nxt;
      oam_wren <= oam_wren_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
    end
  end

endmodule
